// File: rtl/mem_map_pkg.sv
// Address map of the data SRAM responder: config offsets, default region tag, byte-lane merge.
// Shared by the responder top and anything that decodes the same map.
package mem_map_pkg;

    localparam logic [15:0] CONF_BASE_HI_DEFAULT = 16'h1faf;

    localparam logic [15:0] LED_OFF    = 16'h0000;
    localparam logic [15:0] SWITCH_OFF = 16'h0004;
    localparam logic [15:0] NUM_OFF    = 16'h0008;
    localparam logic [15:0] TIMER_OFF  = 16'h000c;
    localparam logic [15:0] SIMU_OFF   = 16'h0010;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  lane_we);
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) m[8*i +: 8] = new_w[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_we_ram.sv
// Word RAM with four byte-lane write enables and a registered synchronous read port.
// Read data loads only on read requests and holds otherwise; contents are never reset.
module byte_we_ram #(
    parameter int RAM_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [RAM_AW-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**RAM_AW];
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && (we == 4'h0)) rdata_d = mem[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-writable RAM plus a config register block, 1-cycle read latency, no stalls.
// Define CONFREG_TIMER_EN to build the free-running TIMER register; otherwise its offset reads 0.
module data_sram_responder
    import mem_map_pkg::*;
#(
    parameter int          RAM_AW       = 14,
    parameter logic [15:0] CONF_BASE_HI = CONF_BASE_HI_DEFAULT,
    parameter bit          SIMU         = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    logic        is_conf, rd_req, wr_conf;
    logic [15:0] off_w;
    logic [31:0] conf_rd_val, ram_rdata;
    logic        unused_ok;

    logic        sel_conf_q, sel_conf_d;
    logic [31:0] conf_rdata_q, conf_rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [7:0]  sw_meta_q, sw_meta_d;
    logic [7:0]  sw_sync_q, sw_sync_d;

    assign is_conf   = (addr[31:16] == CONF_BASE_HI);
    assign off_w     = {addr[15:2], 2'b00};
    assign rd_req    = en && (we == 4'h0);
    assign wr_conf   = en && (we != 4'h0) && is_conf;
    assign unused_ok = ^addr[1:0];

    byte_we_ram #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (en && !is_conf),
        .we    (we),
        .idx   (addr[RAM_AW+1:2]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

`ifdef CONFREG_TIMER_EN
    logic [31:0] timer_q, timer_d;

    // A write replaces this cycle's increment; counting resumes from the written value.
    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wr_conf && (off_w == TIMER_OFF)) timer_d = merge_lanes(timer_q, wdata, we);
    end

    always_ff @(posedge clk) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
`endif

    always_comb begin
        conf_rd_val = '0;
        case (off_w)
            LED_OFF:    conf_rd_val = {16'b0, led_q};
            SWITCH_OFF: conf_rd_val = {24'b0, sw_sync_q};
            NUM_OFF:    conf_rd_val = num_q;
`ifdef CONFREG_TIMER_EN
            TIMER_OFF:  conf_rd_val = timer_q;
`endif
            SIMU_OFF:   conf_rd_val = {31'b0, SIMU};
            default:    ;
        endcase
    end

    always_comb begin
        sel_conf_d   = rd_req ? is_conf : sel_conf_q;
        conf_rdata_d = (rd_req && is_conf) ? conf_rd_val : conf_rdata_q;
        sw_meta_d    = switch_in;
        sw_sync_d    = sw_meta_q;
        led_d        = led_q;
        num_d        = num_q;
        if (wr_conf && (off_w == LED_OFF)) begin
            led_d[7:0]  = we[0] ? wdata[7:0]  : led_q[7:0];
            led_d[15:8] = we[1] ? wdata[15:8] : led_q[15:8];
        end
        if (wr_conf && (off_w == NUM_OFF)) num_d = merge_lanes(num_q, wdata, we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_conf_q   <= 1'b0;
            conf_rdata_q <= '0;
            led_q        <= '0;
            num_q        <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
        end else begin
            sel_conf_q   <= sel_conf_d;
            conf_rdata_q <= conf_rdata_d;
            led_q        <= led_d;
            num_q        <= num_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
        end
    end

    // Both read registers clear on reset, so the mux output is 0 straight after reset.
    assign rdata   = sel_conf_q ? conf_rdata_q : ram_rdata;
    assign led_out = led_q;
    assign num_out = num_q;

endmodule
